// File: rtl/data_mem_mmio_pkg.sv
// Purpose: shared constants for the data-side memory/MMIO responder (offsets, bit indices, ID, decode regions).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_mmio_pkg;

    // MMIO register offsets within the 8-word window
    localparam logic [2:0] OFF_CTRL    = 3'd0;
    localparam logic [2:0] OFF_LOAD    = 3'd1;
    localparam logic [2:0] OFF_COUNT   = 3'd2;
    localparam logic [2:0] OFF_STATUS  = 3'd3;
    localparam logic [2:0] OFF_CYC_LO  = 3'd4;
    localparam logic [2:0] OFF_CYC_HI  = 3'd5;
    localparam logic [2:0] OFF_SCRATCH = 3'd6;
    localparam logic [2:0] OFF_ID      = 3'd7;

    // CTRL bit indices
    localparam int CTRL_EN     = 0;
    localparam int CTRL_AUTO   = 1;
    localparam int CTRL_IRQ_EN = 2;

    // STATUS bit indices
    localparam int ST_EXPIRED = 0;
    localparam int ST_BUS_ERR = 1;

    localparam logic [15:0] MMIO_ID = 16'hC4A0;

    // Which target the current address selects
    typedef enum logic [1:0] {
        RGN_UNMAPPED = 2'd0,
        RGN_MMIO     = 2'd1,
        RGN_LOW      = 2'd2,
        RGN_STACK    = 2'd3
    } region_e;

endpackage

// File: rtl/data_mem_mmio_if.sv
// Purpose: CPU data-bus bundle (address, store data, write strobe, read data, timer irq, bus error).
// Latency: n/a (wiring only).
// Backpressure: none; the responder accepts every access in the cycle it is presented.
interface data_mem_mmio_if;
    logic [15:0] data_Addr;
    logic [15:0] write_data;
    logic        write_enable;
    logic [15:0] read_data;
    logic        timer_irq;
    logic        bus_err;

    modport master (
        output data_Addr, write_data, write_enable,
        input  read_data, timer_irq, bus_err
    );

    modport slave (
        input  data_Addr, write_data, write_enable,
        output read_data, timer_irq, bus_err
    );
endinterface

// File: rtl/data_mem_mmio_timer.sv
// Purpose: down-counting timer: CTRL/LOAD/COUNT registers, sticky EXPIRED flag and per-cycle tick.
// Latency: register writes visible the cycle after the posedge; expire pulse is combinational from state.
// Backpressure: none; write strobes are always accepted.
module mmio_timer
    import dmem_mmio_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wr_ctrl,
    input  logic        i_wr_load,
    input  logic        i_wr_count,
    input  logic        i_wr_status,
    input  logic [15:0] i_wdata,
    output logic [2:0]  o_ctrl,
    output logic [15:0] o_load,
    output logic [15:0] o_count,
    output logic        o_expired,
    output logic        o_expire
);

    logic [2:0]  r_ctrl;
    logic [15:0] r_load;
    logic [15:0] r_count;
    logic        r_expired;
    logic [15:0] w_count_nxt;
    logic        w_expire;

    // The tick always uses the current (pre-write) CTRL, so a CTRL write only affects later cycles
    assign w_expire = r_ctrl[CTRL_EN] && (r_count == 16'd1);

    // Next COUNT: a CPU write overrides both decrement and reload
    always_comb begin
        w_count_nxt = r_count;
        if (i_wr_count) begin
            w_count_nxt = i_wdata;
        end else if (r_ctrl[CTRL_EN]) begin
            if (r_count == 16'd1) begin
                w_count_nxt = r_ctrl[CTRL_AUTO] ? r_load : 16'd0;
            end else if (r_count > 16'd1) begin
                w_count_nxt = r_count - 16'd1;
            end
        end
    end

    // Timer register state; an expiry beats a same-cycle W1C of EXPIRED
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl    <= '0;
            r_load    <= '0;
            r_count   <= '0;
            r_expired <= 1'b0;
        end else begin
            if (i_wr_ctrl) r_ctrl <= i_wdata[2:0];
            if (i_wr_load) r_load <= i_wdata;
            r_count <= w_count_nxt;
            if (w_expire) begin
                r_expired <= 1'b1;
            end else if (i_wr_status && i_wdata[ST_EXPIRED]) begin
                r_expired <= 1'b0;
            end
        end
    end

    assign o_ctrl    = r_ctrl;
    assign o_load    = r_load;
    assign o_count   = r_count;
    assign o_expired = r_expired;
    assign o_expire  = w_expire;

endmodule

// File: rtl/data_mem_mmio.sv
// Purpose: CPU data-bus responder: low RAM, top-of-memory stack RAM and an 8-word MMIO window.
// Latency: reads are combinational (0 cycles); writes land at the posedge and are visible next cycle.
// Backpressure: none; every access completes in the cycle it is presented.
module data_mem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int          LOW_AW    = 9,
    parameter int          STK_AW    = 8,
    parameter logic [15:0] MMIO_BASE = 16'h8000
) (
    input  logic             clk,
    input  logic             rst,
    data_mem_mmio_if.slave   bus
);

    localparam int LOW_WORDS = 1 << LOW_AW;
    localparam int STK_WORDS = 1 << STK_AW;

    logic [15:0] r_low_mem [0:LOW_WORDS-1];
    logic [15:0] r_stk_mem [0:STK_WORDS-1];

    logic [15:0] w_addr;
    logic [15:0] w_wdata;
    logic        w_we;
    logic [2:0]  w_off;
    region_e     w_region;
    logic        w_mmio_wr;
    logic        w_bus_err_set;
    logic [15:0] w_rdata;

    logic [31:0] r_cyc;
    logic [15:0] r_cyc_hi_snap;
    logic [15:0] r_scratch;
    logic        r_bus_err;

    logic [2:0]  w_ctrl;
    logic [15:0] w_load;
    logic [15:0] w_count;
    logic        w_expired;
    logic        w_expire_pulse;
    logic        w_unused_expire;

    assign w_addr  = bus.data_Addr;
    assign w_wdata = bus.write_data;
    assign w_we    = bus.write_enable;
    assign w_off   = w_addr[2:0];

    // Address decode: MMIO window first, then low RAM, then stack RAM
    always_comb begin
        w_region = RGN_UNMAPPED;
        if (w_addr[15:3] == MMIO_BASE[15:3]) begin
            w_region = RGN_MMIO;
        end else if (w_addr[15:LOW_AW] == '0) begin
            w_region = RGN_LOW;
        end else if (&w_addr[15:STK_AW]) begin
            w_region = RGN_STACK;
        end
    end

    assign w_mmio_wr     = w_we && (w_region == RGN_MMIO);
    assign w_bus_err_set = w_we && ((w_region == RGN_UNMAPPED) ||
                                    ((w_region == RGN_MMIO) && (w_off == OFF_ID)));

    // RAM writes; contents survive reset
    always_ff @(posedge clk) begin
        if (w_we && (w_region == RGN_LOW))   r_low_mem[w_addr[LOW_AW-1:0]] <= w_wdata;
        if (w_we && (w_region == RGN_STACK)) r_stk_mem[w_addr[STK_AW-1:0]] <= w_wdata;
    end

    mmio_timer u_timer (
        .clk         (clk),
        .rst         (rst),
        .i_wr_ctrl   (w_mmio_wr && (w_off == OFF_CTRL)),
        .i_wr_load   (w_mmio_wr && (w_off == OFF_LOAD)),
        .i_wr_count  (w_mmio_wr && (w_off == OFF_COUNT)),
        .i_wr_status (w_mmio_wr && (w_off == OFF_STATUS)),
        .i_wdata     (w_wdata),
        .o_ctrl      (w_ctrl),
        .o_load      (w_load),
        .o_count     (w_count),
        .o_expired   (w_expired),
        .o_expire    (w_expire_pulse)
    );

    // The expire pulse is not needed here: EXPIRED and the IRQ are taken from the sticky flop
    assign w_unused_expire = w_expire_pulse;

    // Cycle counter, CYC_HI snapshot on CYC_LO reads, scratch and sticky bus error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc         <= '0;
            r_cyc_hi_snap <= '0;
            r_scratch     <= '0;
            r_bus_err     <= 1'b0;
        end else begin
            if (w_mmio_wr && ((w_off == OFF_CYC_LO) || (w_off == OFF_CYC_HI))) begin
                r_cyc <= '0;
            end else begin
                r_cyc <= r_cyc + 32'd1;
            end
            if (!w_we && (w_region == RGN_MMIO) && (w_off == OFF_CYC_LO)) begin
                r_cyc_hi_snap <= r_cyc[31:16];
            end
            if (w_mmio_wr && (w_off == OFF_SCRATCH)) r_scratch <= w_wdata;
            if (w_bus_err_set) begin
                r_bus_err <= 1'b1;
            end else if (w_mmio_wr && (w_off == OFF_STATUS) && w_wdata[ST_BUS_ERR]) begin
                r_bus_err <= 1'b0;
            end
        end
    end

    // Combinational read mux; unmapped addresses read as zero
    always_comb begin
        w_rdata = '0;
        case (w_region)
            RGN_LOW:   w_rdata = r_low_mem[w_addr[LOW_AW-1:0]];
            RGN_STACK: w_rdata = r_stk_mem[w_addr[STK_AW-1:0]];
            RGN_MMIO: begin
                case (w_off)
                    OFF_CTRL:    w_rdata = {13'd0, w_ctrl};
                    OFF_LOAD:    w_rdata = w_load;
                    OFF_COUNT:   w_rdata = w_count;
                    OFF_STATUS:  w_rdata = {14'd0, r_bus_err, w_expired};
                    OFF_CYC_LO:  w_rdata = r_cyc[15:0];
                    OFF_CYC_HI:  w_rdata = r_cyc_hi_snap;
                    OFF_SCRATCH: w_rdata = r_scratch;
                    default:     w_rdata = MMIO_ID;
                endcase
            end
            default:   w_rdata = '0;
        endcase
    end

    assign bus.read_data = w_rdata;
    assign bus.timer_irq = w_expired & w_ctrl[CTRL_IRQ_EN];
    assign bus.bus_err   = r_bus_err;

endmodule

// File: tb/tb_data_mem_mmio.sv
// Purpose: self-checking bench for data_mem_mmio: RAM, timer, cycle counter, bus error and reset.
// Latency: reads sampled 1 time unit after address change; writes take one clock.
// Backpressure: n/a.
module tb_data_mem_mmio;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] exp_q [$];
    logic [15:0] rd;
    logic [15:0] e;

    data_mem_mmio_if bus ();

    data_mem_mmio dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // combinational read: drive address, let it settle, no clock advance
    task automatic bus_rd(input logic [15:0] addr, output logic [15:0] data);
        bus.data_Addr    = addr;
        bus.write_enable = 1'b0;
        #1;
        data = bus.read_data;
    endtask

    // one-cycle write issued at a negedge, strobe dropped at the next negedge
    task automatic bus_wr(input logic [15:0] addr, input logic [15:0] data);
        bus.data_Addr    = addr;
        bus.write_data   = data;
        bus.write_enable = 1'b1;
        @(negedge clk);
        bus.write_enable = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.data_Addr = 16'h0000; bus.write_data = 16'h0000; bus.write_enable = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(16'hC4A0); bus_rd(16'h8007, rd);
        e = exp_q.pop_front(); checks++; if (rd !== e) begin errors++; $display("FAIL reset_id: got %h want %h", rd, e); end
        exp_q.push_back(16'h0000); bus_rd(16'h8000, rd);
        e = exp_q.pop_front(); checks++; if (rd !== e) begin errors++; $display("FAIL reset_ctrl: got %h want %h", rd, e); end
        exp_q.push_back(16'h0000); bus_rd(16'h8003, rd);
        e = exp_q.pop_front(); checks++; if (rd !== e) begin errors++; $display("FAIL reset_status: got %h want %h", rd, e); end
        exp_q.push_back(16'h0000);
        e = exp_q.pop_front(); checks++; if ({14'd0, bus.timer_irq, bus.bus_err} !== e) begin errors++; $display("FAIL reset_irq_err: got irq=%b err=%b want 0 0", bus.timer_irq, bus.bus_err); end
    endtask

    task automatic test_ram();
        bus_wr(16'h0005, 16'h1111);
        bus.data_Addr = 16'h0005; bus.write_data = 16'h1234; bus.write_enable = 1'b1;
        exp_q.push_back(16'h1111); #1; rd = bus.read_data;
        e = exp_q.pop_front(); checks++; if (rd !== e) begin errors++; $display("FAIL ram_rdw_old: got %h want %h", rd, e); end
        @(negedge clk); bus.write_enable = 1'b0;
        exp_q.push_back(16'h1234); bus_rd(16'h0005, rd);
        e = exp_q.pop_front(); checks++; if (rd !== e) begin errors++; $display("FAIL ram_low: got %h want %h", rd, e); end
        bus_wr(16'hFFFF, 16'hBEEF);
        exp_q.push_back(16'hBEEF); bus_rd(16'hFFFF, rd);
        e = exp_q.pop_front(); checks++; if (rd !== e) begin errors++; $display("FAIL ram_stack_top: got %h want %h", rd, e); end
        bus_wr(16'hFF05, 16'hAAAA);
        bus_wr(16'h01FF, 16'h7777);
        exp_q.push_back(16'h1234); bus_rd(16'h0005, rd);
        e = exp_q.pop_front(); checks++; if (rd !== e) begin errors++; $display("FAIL ram_no_alias: got %h want %h", rd, e); end
        exp_q.push_back(16'hAAAA); bus_rd(16'hFF05, rd);
        e = exp_q.pop_front(); checks++; if (rd !== e) begin errors++; $display("FAIL ram_stack: got %h want %h", rd, e); end
        exp_q.push_back(16'h7777); bus_rd(16'h01FF, rd);
        e = exp_q.pop_front(); checks++; if (rd !== e) begin errors++; $display("FAIL ram_low_top: got %h want %h", rd, e); end
        exp_q.push_back(16'h0000); bus_rd(16'h0200, rd);
        e = exp_q.pop_front(); checks++; if (rd !== e) begin errors++; $display("FAIL unmapped_above_low: got %h want %h", rd, e); end
        @(negedge clk);
        exp_q.push_back(16'h0000);
        e = exp_q.pop_front(); checks++; if ({15'd0, bus.bus_err} !== e) begin errors++; $display("FAIL ram_no_bus_err: got %b want 0", bus.bus_err); end
    endtask

    task automatic test_scratch_ctrl();
        bus_wr(16'h8006, 16'h5A5A);
        exp_q.push_back(16'h5A5A); bus_rd(16'h8006, rd);
        e = exp_q.pop_front(); checks++; if (rd !== e) begin errors++; $display("FAIL scratch: got %h want %h", rd, e); end
        bus_wr(16'h8000, 16'hFFF8);
        exp_q.push_back(16'h0000); bus_rd(16'h8000, rd);
        e = exp_q.pop_front(); checks++; if (rd !== e) begin errors++; $display("FAIL ctrl_upper_bits: got %h want %h", rd, e); end
    endtask

    task automatic test_timer_auto();
        logic [15:0] m_cnt;
        logic        m_exp;
        bus_wr(16'h8001, 16'd3);
        bus_wr(16'h8000, 16'h0007);
        bus_wr(16'h8002, 16'd3);
        m_cnt = 16'd3; m_exp = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                @(negedge clk);
                if (m_cnt == 16'd1) begin m_exp = 1'b1; m_cnt = 16'd3; end
                else if (m_cnt > 16'd1) m_cnt = m_cnt - 16'd1;
            end
            exp_q.push_back(m_cnt); bus_rd(16'h8002, rd);
            e = exp_q.pop_front(); checks++; if (rd !== e) begin errors++; $display("FAIL auto_count[%0d]: got %h want %h", i, rd, e); end
            exp_q.push_back({15'd0, m_exp});
            e = exp_q.pop_front(); checks++; if ({15'd0, bus.timer_irq} !== e) begin errors++; $display("FAIL auto_irq[%0d]: got %b want %b", i, bus.timer_irq, e[0]); end
        end
        // count is 1 here: the W1C collides with an expiry
        bus_wr(16'h8003, 16'h0001);
        exp_q.push_back(16'h0001); bus_rd(16'h8003, rd);
        e = exp_q.pop_front(); checks++; if (rd !== e) begin errors++; $display("FAIL w1c_vs_expire: got %h want %h", rd, e); end
        exp_q.push_back(16'd3); bus_rd(16'h8002, rd);
        e = exp_q.pop_front(); checks++; if (rd !== e) begin errors++; $display("FAIL auto_reload: got %h want %h", rd, e); end
        bus_wr(16'h8003, 16'h0001);
        exp_q.push_back(16'h0000); bus_rd(16'h8003, rd);
        e = exp_q.pop_front(); checks++; if (rd !== e) begin errors++; $display("FAIL w1c_clear: got %h want %h", rd, e); end
        exp_q.push_back(16'h0000);
        e = exp_q.pop_front(); checks++; if ({15'd0, bus.timer_irq} !== e) begin errors++; $display("FAIL irq_after_clear: got %b want 0", bus.timer_irq); end
    endtask

    task automatic test_timer_oneshot();
        logic [15:0] want [4];
        want[0] = 16'd2; want[1] = 16'd1; want[2] = 16'd0; want[3] = 16'd0;
        bus_wr(16'h8000, 16'h0000);
        bus_wr(16'h8003, 16'h0001);
        bus_wr(16'h8002, 16'd2);
        bus_wr(16'h8000, 16'h0001);
        exp_q.push_back(16'h0001); bus_rd(16'h8000, rd);
        e = exp_q.pop_front(); checks++; if (rd !== e) begin errors++; $display("FAIL oneshot_ctrl: got %h want %h", rd, e); end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            exp_q.push_back(want[i]); bus_rd(16'h8002, rd);
            e = exp_q.pop_front(); checks++; if (rd !== e) begin errors++; $display("FAIL oneshot_count[%0d]: got %h want %h", i, rd, e); end
        end
        exp_q.push_back(16'h0001); bus_rd(16'h8003, rd);
        e = exp_q.pop_front(); checks++; if (rd !== e) begin errors++; $display("FAIL oneshot_expired: got %h want %h", rd, e); end
        exp_q.push_back(16'h0000);
        e = exp_q.pop_front(); checks++; if ({15'd0, bus.timer_irq} !== e) begin errors++; $display("FAIL oneshot_irq_masked: got %b want 0", bus.timer_irq); end
    endtask

    task automatic test_bus_err();
        exp_q.push_back(16'h0000); bus_rd(16'h4000, rd);
        e = exp_q.pop_front(); checks++; if (rd !== e) begin errors++; $display("FAIL unmapped_read: got %h want %h", rd, e); end
        @(negedge clk);
        exp_q.push_back(16'h0000);
        e = exp_q.pop_front(); checks++; if ({15'd0, bus.bus_err} !== e) begin errors++; $display("FAIL read_no_err: got %b want 0", bus.bus_err); end
        bus_wr(16'h4000, 16'h5555);
        exp_q.push_back(16'h0001);
        e = exp_q.pop_front(); checks++; if ({15'd0, bus.bus_err} !== e) begin errors++; $display("FAIL unmapped_write_err: got %b want 1", bus.bus_err); end
        exp_q.push_back(16'h0003); bus_rd(16'h8003, rd);
        e = exp_q.pop_front(); checks++; if (rd !== e) begin errors++; $display("FAIL status_both: got %h want %h", rd, e); end
        bus_wr(16'h8003, 16'h0002);
        exp_q.push_back(16'h0001); bus_rd(16'h8003, rd);
        e = exp_q.pop_front(); checks++; if (rd !== e) begin errors++; $display("FAIL clear_bus_err: got %h want %h", rd, e); end
        bus_wr(16'h8007, 16'h1234);
        exp_q.push_back(16'h0001);
        e = exp_q.pop_front(); checks++; if ({15'd0, bus.bus_err} !== e) begin errors++; $display("FAIL id_write_err: got %b want 1", bus.bus_err); end
        exp_q.push_back(16'hC4A0); bus_rd(16'h8007, rd);
        e = exp_q.pop_front(); checks++; if (rd !== e) begin errors++; $display("FAIL id_unchanged: got %h want %h", rd, e); end
        exp_q.push_back(16'h5A5A); bus_rd(16'h8006, rd);
        e = exp_q.pop_front(); checks++; if (rd !== e) begin errors++; $display("FAIL scratch_unchanged: got %h want %h", rd, e); end
        bus_wr(16'h8003, 16'h0003);
        exp_q.push_back(16'h0000); bus_rd(16'h8003, rd);
        e = exp_q.pop_front(); checks++; if (rd !== e) begin errors++; $display("FAIL status_cleared: got %h want %h", rd, e); end
    endtask

    task automatic test_reset_mid();
        bus_wr(16'h8002, 16'd10);
        bus_wr(16'h8000, 16'h0007);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(16'h0000); bus_rd(16'h8002, rd);
        e = exp_q.pop_front(); checks++; if (rd !== e) begin errors++; $display("FAIL mid_reset_count: got %h want %h", rd, e); end
        repeat (12) @(negedge clk);
        exp_q.push_back(16'h0000); bus_rd(16'h8003, rd);
        e = exp_q.pop_front(); checks++; if (rd !== e) begin errors++; $display("FAIL mid_reset_no_event: got %h want %h", rd, e); end
        exp_q.push_back(16'h1234); bus_rd(16'h0005, rd);
        e = exp_q.pop_front(); checks++; if (rd !== e) begin errors++; $display("FAIL ram_kept_over_reset: got %h want %h", rd, e); end
    endtask

    task automatic test_cycle_counter();
        logic [31:0] m_cyc;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_cyc = 32'd0;
        repeat (70000) begin @(negedge clk); m_cyc = m_cyc + 32'd1; end
        exp_q.push_back(m_cyc[15:0]); bus_rd(16'h8004, rd);
        e = exp_q.pop_front(); checks++; if (rd !== e) begin errors++; $display("FAIL cyc_lo: got %h want %h", rd, e); end
        exp_q.push_back(m_cyc[31:16]);
        @(negedge clk); m_cyc = m_cyc + 32'd1;
        bus_rd(16'h8005, rd);
        e = exp_q.pop_front(); checks++; if (rd !== e) begin errors++; $display("FAIL cyc_hi_snapshot: got %h want %h", rd, e); end
        exp_q.push_back(m_cyc[15:0]); bus_rd(16'h8004, rd);
        e = exp_q.pop_front(); checks++; if (rd !== e) begin errors++; $display("FAIL cyc_lo_next: got %h want %h", rd, e); end
        bus_wr(16'h8004, 16'hFFFF);
        exp_q.push_back(16'h0000); bus_rd(16'h8004, rd);
        e = exp_q.pop_front(); checks++; if (rd !== e) begin errors++; $display("FAIL cyc_clear: got %h want %h", rd, e); end
        @(negedge clk);
        exp_q.push_back(16'h0000); bus_rd(16'h8005, rd);
        e = exp_q.pop_front(); checks++; if (rd !== e) begin errors++; $display("FAIL cyc_hi_after_clear: got %h want %h", rd, e); end
        exp_q.push_back(16'h0001); bus_rd(16'h8004, rd);
        e = exp_q.pop_front(); checks++; if (rd !== e) begin errors++; $display("FAIL cyc_count_after_clear: got %h want %h", rd, e); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_scratch_ctrl();
        test_timer_auto();
        test_timer_oneshot();
        test_bus_err();
        test_reset_mid();
        test_cycle_counter();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
